// File: rtl/capture_if.sv
// Sample/control bundle between the signal generator side and the capture buffer.
// master drives samples and controls; slave is the buffer itself.
interface capture_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  trigger;
    logic                  arm;
    logic                  rd_en;
    logic                  primed;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output data, trigger, arm, rd_en,
        input  primed, busy, done, rd_data, rd_valid
    );

    modport slave (
        input  data, trigger, arm, rd_en,
        output primed, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/capture_buffer.sv
// Trigger-qualified circular sample store: pre-trigger history plus a fixed
// post-trigger window, replayed oldest-first on rd_en.
module capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PRE_TRIG   = 4
) (
    input  logic     clk,
    input  logic     reset,
    capture_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int POST_LEN = DEPTH - PRE_TRIG;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        PRIMED = 3'd2,
        POST   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic                  we_s;
    logic                  rd_s;
    logic                  trig_s;
    logic [AW-1:0]         wp_r;
    logic [AW-1:0]         rp_r;
    logic [AW-1:0]         tp_r;
    logic [CW-1:0]         cnt_r;
    logic                  primed_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Next-state and per-edge write/read/trigger-accept decisions
    always_comb begin
        state_nx_s = state_r;
        we_s       = 1'b0;
        rd_s       = 1'b0;
        trig_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.arm) state_nx_s = FILL;
                else         state_nx_s = IDLE;
            end
            FILL: begin
                we_s = 1'b1;
                if (cnt_r == CW'(PRE_TRIG - 1)) state_nx_s = PRIMED;
                else                            state_nx_s = FILL;
            end
            PRIMED: begin
                we_s = 1'b1;
                if (bus.trigger) begin
                    trig_s     = 1'b1;
                    state_nx_s = (POST_LEN == 1) ? DONE : POST;
                end else begin
                    state_nx_s = PRIMED;
                end
            end
            POST: begin
                we_s = 1'b1;
                if (cnt_r == CW'(POST_LEN - 1)) state_nx_s = DONE;
                else                            state_nx_s = POST;
            end
            DONE: begin
                if (bus.rd_en) begin
                    rd_s = 1'b1;
                    if (cnt_r == CW'(DEPTH - 1)) state_nx_s = IDLE;
                    else                         state_nx_s = DONE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            wp_r       <= '0;
            rp_r       <= '0;
            tp_r       <= '0;
            cnt_r      <= '0;
            primed_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            state_r <= state_nx_s;

            if (state_r == IDLE && state_nx_s == FILL) wp_r <= '0;
            else if (we_s)                             wp_r <= wp_r + AW'(1);

            // The trigger sample is post sample #1, so POST starts counting at one
            if (state_nx_s != state_r)
                cnt_r <= (state_nx_s == POST) ? CW'(1) : CW'(0);
            else if (state_r == FILL || state_r == POST || rd_s)
                cnt_r <= cnt_r + CW'(1);

            if (trig_s) tp_r <= wp_r;

            // When the trigger itself ends the capture, tp_r is not yet loaded
            if (state_nx_s == DONE && state_r != DONE)
                rp_r <= (trig_s ? wp_r : tp_r) - AW'(PRE_TRIG);
            else if (rd_s)
                rp_r <= rp_r + AW'(1);

            primed_r   <= (state_nx_s == PRIMED);
            busy_r     <= (state_nx_s == FILL) || (state_nx_s == PRIMED) || (state_nx_s == POST);
            done_r     <= (state_nx_s == DONE);
            rd_valid_r <= rd_s;
            if (rd_s) rd_data_r <= mem_r[rp_r];
        end
    end

    // Sample RAM, intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (we_s) mem_r[wp_r] <= bus.data;
    end

    assign bus.primed   = primed_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: default instance plus a PRE_TRIG=15 instance,
// readout checked against a queue of expected samples.
module tb_capture_buffer;
    logic       clk     = 1'b0;
    logic       reset_v = 1'b0;
    logic [7:0] data_v  = 8'd0;
    logic       trig_v  = 1'b0;
    logic       rd_v    = 1'b0;
    logic       arm0_v  = 1'b0;
    logic       arm1_v  = 1'b0;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         sample_n  = 0;
    logic [7:0] sbq [$];

    capture_if #(.DATA_WIDTH(8)) bus0 ();
    capture_if #(.DATA_WIDTH(8)) bus1 ();

    assign bus0.data    = data_v;
    assign bus0.trigger = trig_v;
    assign bus0.rd_en   = rd_v;
    assign bus0.arm     = arm0_v;
    assign bus1.data    = data_v;
    assign bus1.trigger = trig_v;
    assign bus1.rd_en   = rd_v;
    assign bus1.arm     = arm1_v;

    capture_buffer #(.DATA_WIDTH(8), .DEPTH(16), .PRE_TRIG(4)) u0 (
        .clk(clk), .reset(reset_v), .bus(bus0)
    );
    capture_buffer #(.DATA_WIDTH(8), .DEPTH(16), .PRE_TRIG(15)) u1 (
        .clk(clk), .reset(reset_v), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One generator sample: data counts from 0 at the first write edge after arm
    task automatic samp(input logic trig);
        data_v = 8'(sample_n);
        trig_v = trig;
        tick();
        sample_n++;
    endtask

    task automatic arm_dut(input int sel);
        if (sel == 1) arm1_v = 1'b1;
        else          arm0_v = 1'b1;
        tick();
        arm0_v   = 1'b0;
        arm1_v   = 1'b0;
        sample_n = 0;
        check("arm_busy", (sel == 1) ? bus1.busy : bus0.busy, 32'd1);
    endtask

    task automatic expect_window(input int trig_at, input int pre);
        for (int i = 0; i < 16; i++) sbq.push_back(8'(trig_at - pre + i));
    endtask

    task automatic readout(input int sel);
        logic [7:0] exp_v;
        trig_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_v = 1'b1;
            tick();
            if (sbq.size() == 0) begin
                total_cnt++;
                $error("FAIL sb_empty observed=0 expected=1");
            end else begin
                exp_v = sbq.pop_front();
                check("rd_valid", (sel == 1) ? bus1.rd_valid : bus0.rd_valid, 32'd1);
                check("rd_data", (sel == 1) ? bus1.rd_data : bus0.rd_data, 32'(exp_v));
                check("done_during_rd", (sel == 1) ? bus1.done : bus0.done, (i < 15) ? 32'd1 : 32'd0);
            end
        end
        rd_v = 1'b0;
        tick();
        check("rd_valid_after", (sel == 1) ? bus1.rd_valid : bus0.rd_valid, 32'd0);
        check("idle_busy", (sel == 1) ? bus1.busy : bus0.busy, 32'd0);
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            data_v = 8'($urandom);
            trig_v = 1'($urandom);
            rd_v   = 1'($urandom);
            arm0_v = 1'($urandom);
            tick();
        end
        check("rst_primed", bus0.primed, 32'd0);
        check("rst_busy", bus0.busy, 32'd0);
        check("rst_done", bus0.done, 32'd0);
        check("rst_rd_valid", bus0.rd_valid, 32'd0);
        check("rst_rd_data", bus0.rd_data, 32'd0);
        trig_v = 1'b0; rd_v = 1'b0; arm0_v = 1'b0;
        reset_v = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_busy", bus0.busy, 32'd0);
        check("idle_done", bus0.done, 32'd0);
        check("idle_primed", bus0.primed, 32'd0);

        // Basic capture with ignored arm in PRIMED and rd_en in POST
        arm_dut(0);
        check("arm_primed", bus0.primed, 32'd0);
        for (int i = 0; i < 3; i++) samp(1'b0);
        check("primed_early", bus0.primed, 32'd0);
        samp(1'b0);
        check("primed_rise", bus0.primed, 32'd1);
        samp(1'b0); samp(1'b0);
        arm0_v = 1'b1; samp(1'b0); arm0_v = 1'b0;
        check("arm_in_primed", bus0.primed, 32'd1);
        samp(1'b0); samp(1'b0); samp(1'b0);
        samp(1'b1);
        expect_window(10, 4);
        check("primed_fall", bus0.primed, 32'd0);
        check("post_busy", bus0.busy, 32'd1);
        samp(1'b0);
        rd_v = 1'b1; samp(1'b0); rd_v = 1'b0;
        check("rd_in_post", bus0.rd_valid, 32'd0);
        while (sample_n < 21) samp(1'b0);
        check("done_early", bus0.done, 32'd0);
        samp(1'b0);
        check("done_rise", bus0.done, 32'd1);
        check("done_busy", bus0.busy, 32'd0);
        arm0_v = 1'b1; tick(); arm0_v = 1'b0;
        check("arm_in_done", bus0.done, 32'd1);
        check("arm_in_done_busy", bus0.busy, 32'd0);
        readout(0);
        rd_v = 1'b1; tick(); rd_v = 1'b0;
        check("rd_in_idle", bus0.rd_valid, 32'd0);

        // Trigger held during FILL is ignored
        arm_dut(0);
        for (int i = 0; i < 4; i++) samp(1'b1);
        samp(1'b0);
        samp(1'b1);
        expect_window(5, 4);
        while (sample_n < 17) samp(1'b0);
        check("fill_trig_done", bus0.done, 32'd1);
        readout(0);

        // Wrap-around of the read start pointer
        arm_dut(0);
        while (sample_n < 37) samp(1'b0);
        samp(1'b1);
        expect_window(37, 4);
        while (sample_n < 49) samp(1'b0);
        check("wrap_done", bus0.done, 32'd1);
        readout(0);

        // Reset mid-POST aborts, then a clean capture follows
        arm_dut(0);
        while (sample_n < 10) samp(1'b0);
        samp(1'b1);
        while (sample_n < 15) samp(1'b0);
        #1 reset_v = 1'b0;
        #1;
        check("abort_primed", bus0.primed, 32'd0);
        check("abort_busy", bus0.busy, 32'd0);
        check("abort_done", bus0.done, 32'd0);
        tick();
        reset_v = 1'b1;
        tick();
        arm_dut(0);
        while (sample_n < 10) samp(1'b0);
        samp(1'b1);
        expect_window(10, 4);
        while (sample_n < 22) samp(1'b0);
        check("rearm_done", bus0.done, 32'd1);
        readout(0);

        // PRE_TRIG=15: the trigger sample alone completes the capture
        arm_dut(1);
        while (sample_n < 14) samp(1'b0);
        check("p15_primed_early", bus1.primed, 32'd0);
        samp(1'b1);
        check("p15_primed", bus1.primed, 32'd1);
        while (sample_n < 20) samp(1'b0);
        check("p15_still_primed", bus1.primed, 32'd1);
        samp(1'b1);
        expect_window(20, 15);
        check("p15_done", bus1.done, 32'd1);
        check("p15_busy", bus1.busy, 32'd0);
        check("p15_primed_fall", bus1.primed, 32'd0);
        readout(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
